signed_sat_accumulator: RTL and testbench

- Downstream consumer of the 4-bit signed adder stage.
- Takes a valid/ready stream of two's-complement sums, each with the adder's overflow flag.
- Accumulates COUNT samples into a wider saturating accumulator.
- Emits one frame result with a saturation flag and a sticky overflow flag, then clears and starts the next frame.

---
 rtl/sat_acc_pkg.sv | 27 ++
 rtl/sat_add.sv | 36 +++
 rtl/signed_sat_accumulator.sv | 93 +++++++++
 tb/tb_signed_sat_accumulator.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sat_acc_pkg.sv
// rtl/sat_acc_pkg.sv - shared types and helpers for the signed saturating accumulator
package sat_acc_pkg;

  // Collecting samples vs. presenting a finished frame result
  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Largest value representable in an acc_w-bit two's-complement word
  function automatic int sat_max(input int acc_w);
    return (1 << (acc_w - 1)) - 1;
  endfunction

  // Smallest value representable in an acc_w-bit two's-complement word
  function automatic int sat_min(input int acc_w);
    return -(1 << (acc_w - 1));
  endfunction

  // Sign-extend the low w bits of d to 32 bits; callers truncate to the width they need
  function automatic logic signed [31:0] sext(input logic [31:0] d, input int w);
    logic signed [31:0] t;
    t = d << (32 - w);
    return t >>> (32 - w);
  endfunction

endpackage

// File: rtl/sat_add.sv
// rtl/sat_add.sv - combinational saturating add of a signed sample into the accumulator
module sat_add #(
  parameter int W     = 4,
  parameter int ACC_W = 6
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [W-1:0]     sample,
  output logic [ACC_W-1:0] result,
  output logic             clamp
);
  import sat_acc_pkg::*;

  localparam logic signed [ACC_W:0] MAX_S = (ACC_W + 1)'(sat_max(ACC_W));
  localparam logic signed [ACC_W:0] MIN_S = (ACC_W + 1)'(sat_min(ACC_W));

  logic signed [ACC_W:0] sample_x;
  logic signed [ACC_W:0] sum;

  // One guard bit above the accumulator is enough to hold any single-sample excursion
  assign sample_x = (ACC_W + 1)'(sext(32'(sample), W));

  // Add, then clamp to the rails and flag whenever clamping happened
  always_comb begin
    sum    = $signed({acc[ACC_W-1], acc}) + sample_x;
    result = sum[ACC_W-1:0];
    clamp  = 1'b0;
    if (sum > MAX_S) begin
      result = MAX_S[ACC_W-1:0];
      clamp  = 1'b1;
    end else if (sum < MIN_S) begin
      result = MIN_S[ACC_W-1:0];
      clamp  = 1'b1;
    end
  end

endmodule

// File: rtl/signed_sat_accumulator.sv
// rtl/signed_sat_accumulator.sv - frames COUNT signed samples into a saturating sum (SAT_ACC_BACK_TO_BACK_EN removes the per-frame bubble)
module signed_sat_accumulator #(
  parameter int W     = 4,
  parameter int ACC_W = 6,
  parameter int COUNT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat,
  output logic             out_overflow
);
  import sat_acc_pkg::*;

  localparam int CW = $clog2(COUNT);
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             sat_flag;
  logic             ovf_flag;

  logic [ACC_W-1:0] add_result;
  logic             add_clamp;
  logic             accept;

  sat_add #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_sat_add (
    .acc    (acc),
    .sample (in_data),
    .result (add_result),
    .clamp  (add_clamp)
  );

`ifdef SAT_ACC_BACK_TO_BACK_EN
  // While a result is held, a sample may enter only in the cycle the result leaves
  assign in_ready = (state == ACC) || out_ready;
`else
  // Samples are refused while a result is held, costing one bubble per frame
  assign in_ready = (state == ACC);
`endif

  assign accept = in_valid && in_ready;

  // Frame FSM: accumulate, count, latch the frame result and release it on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ACC;
      acc          <= '0;
      cnt          <= '0;
      sat_flag     <= 1'b0;
      ovf_flag     <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_sat      <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
        state     <= ACC;
      end
      if (accept) begin
        if (cnt == LAST) begin
          // Final sample: publish the frame including this sample, then start clean
          out_data     <= add_result;
          out_sat      <= sat_flag | add_clamp;
          out_overflow <= ovf_flag | in_overflow;
          out_valid    <= 1'b1;
          state        <= HOLD;
          acc          <= '0;
          cnt          <= '0;
          sat_flag     <= 1'b0;
          ovf_flag     <= 1'b0;
        end else begin
          acc      <= add_result;
          cnt      <= cnt + 1'b1;
          sat_flag <= sat_flag | add_clamp;
          ovf_flag <= ovf_flag | in_overflow;
        end
      end
    end
  end

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// tb/tb_signed_sat_accumulator.sv - directed self-checking bench for signed_sat_accumulator
module tb_signed_sat_accumulator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_overflow;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_data;
  logic       out_sat;
  logic       out_overflow;

  int n_pass;
  int n_total;

  signed_sat_accumulator #(
    .W     (4),
    .ACC_W (6),
    .COUNT (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_overflow  (in_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_sat      (out_sat),
    .out_overflow (out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one sample and hold it until it is accepted; returns 1ns after the accepting edge
  task automatic send(input logic [3:0] d, input logic ov);
    int waits;
    waits       = 0;
    in_valid    = 1'b1;
    in_data     = d;
    in_overflow = ov;
    while (!in_ready && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL send_timeout in_ready=%0b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid    = 1'b0;
    in_overflow = 1'b0;
  endtask

  // Complete the output handshake for a held result
  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; in_data = '0; in_overflow = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    #3;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else n_pass++;
    n_total++; if (out_data !== 6'd0) $display("FAIL reset_out_data got %0d want 0", out_data); else n_pass++;
    n_total++; if (out_sat !== 1'b0) $display("FAIL reset_out_sat got %0b want 0", out_sat); else n_pass++;
    n_total++; if (out_overflow !== 1'b0) $display("FAIL reset_out_overflow got %0b want 0", out_overflow); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_basic_sum();
    logic [3:0] v [8];
    v = '{4'd3, 4'hE, 4'd5, 4'd1, 4'd0, 4'hC, 4'd2, 4'd1};
    for (int i = 0; i < 7; i++) send(v[i], 1'b0);
    n_total++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid got %0b want 0", out_valid); else n_pass++;
    send(v[7], 1'b0);
    n_total++; if (out_valid !== 1'b1) $display("FAIL basic_latency got %0b want 1", out_valid); else n_pass++;
    n_total++; if (out_data !== 6'd6) $display("FAIL basic_data got %0d want 6", $signed(out_data)); else n_pass++;
    n_total++; if (out_sat !== 1'b0) $display("FAIL basic_sat got %0b want 0", out_sat); else n_pass++;
    n_total++; if (out_overflow !== 1'b0) $display("FAIL basic_ovf got %0b want 0", out_overflow); else n_pass++;
    drain();
    n_total++; if (out_valid !== 1'b0) $display("FAIL basic_release got %0b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 8; i++) send(4'd7, 1'b0);
    n_total++; if (out_data !== 6'd31) $display("FAIL pos_clamp_data got %0d want 31", $signed(out_data)); else n_pass++;
    n_total++; if (out_sat !== 1'b1) $display("FAIL pos_clamp_sat got %0b want 1", out_sat); else n_pass++;
    drain();
    for (int i = 0; i < 8; i++) send(4'h8, 1'b0);
    n_total++; if (out_data !== 6'b100000) $display("FAIL neg_clamp_data got %0d want -32", $signed(out_data)); else n_pass++;
    n_total++; if (out_sat !== 1'b1) $display("FAIL neg_clamp_sat got %0b want 1", out_sat); else n_pass++;
    drain();
  endtask

  task automatic test_rail_recovery();
    for (int i = 0; i < 5; i++) send(4'd7, 1'b0);
    for (int i = 0; i < 3; i++) send(4'h8, 1'b0);
    n_total++; if (out_data !== 6'd7) $display("FAIL rail_data got %0d want 7", $signed(out_data)); else n_pass++;
    n_total++; if (out_sat !== 1'b1) $display("FAIL rail_sat got %0b want 1", out_sat); else n_pass++;
    drain();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) send(4'd1, (i == 2));
    n_total++; if (out_data !== 6'd8) $display("FAIL ovf_data got %0d want 8", $signed(out_data)); else n_pass++;
    n_total++; if (out_overflow !== 1'b1) $display("FAIL ovf_flag got %0b want 1", out_overflow); else n_pass++;
    n_total++; if (out_sat !== 1'b0) $display("FAIL ovf_sat got %0b want 0", out_sat); else n_pass++;
    drain();
    for (int i = 0; i < 8; i++) send(4'd1, 1'b0);
    n_total++; if (out_overflow !== 1'b0) $display("FAIL ovf_cleared got %0b want 0", out_overflow); else n_pass++;
    n_total++; if (out_data !== 6'd8) $display("FAIL ovf_next_data got %0d want 8", $signed(out_data)); else n_pass++;
    drain();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) send(4'hF, 1'b0);
    in_valid = 1'b1;
    in_data  = 4'd7;
    for (int c = 0; c < 5; c++) begin
      n_total++; if (out_valid !== 1'b1) $display("FAIL bp_valid c%0d got %0b want 1", c, out_valid); else n_pass++;
      n_total++; if (out_data !== 6'b111000) $display("FAIL bp_data c%0d got %0d want -8", c, $signed(out_data)); else n_pass++;
      n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready c%0d got %0b want 0", c, in_ready); else n_pass++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    n_total++; if (out_valid !== 1'b0) $display("FAIL bp_release got %0b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready_after got %0b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 3; i++) send(4'd5, 1'b1);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send(4'd2, 1'b0);
    n_total++; if (out_data !== 6'd16) $display("FAIL rstmid_data got %0d want 16", $signed(out_data)); else n_pass++;
    n_total++; if (out_sat !== 1'b0) $display("FAIL rstmid_sat got %0b want 0", out_sat); else n_pass++;
    n_total++; if (out_overflow !== 1'b0) $display("FAIL rstmid_ovf got %0b want 0", out_overflow); else n_pass++;
    drain();
  endtask

  // Continuous traffic with out_ready held high: frames of all 1, all 2, all -1
  task automatic test_back_to_back();
    logic [5:0] exp_data [3];
    logic [5:0] got_data [3];
    int         got_cyc [3];
    int         idx;
    int         frames;
    int         gap;
    logic       acc_now;
    exp_data = '{6'd8, 6'd16, 6'b111000};
`ifdef SAT_ACC_BACK_TO_BACK_EN
    gap = 8;
`else
    gap = 9;
`endif
    idx    = 0;
    frames = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && frames < 3; cyc++) begin
      in_valid = (idx < 24);
      in_data  = (idx < 8) ? 4'd1 : (idx < 16) ? 4'd2 : 4'hF;
      #1;
      if (out_valid) begin
        got_data[frames] = out_data;
        got_cyc[frames]  = cyc;
        frames++;
      end
      acc_now = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc_now) idx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_total++; if (frames !== 3) $display("FAIL b2b_frames got %0d want 3", frames); else n_pass++;
    if (frames == 3) begin
      for (int f = 0; f < 3; f++) begin
        n_total++;
        if (got_data[f] !== exp_data[f]) $display("FAIL b2b_data f%0d got %0d want %0d", f, $signed(got_data[f]), $signed(exp_data[f]));
        else n_pass++;
      end
      for (int f = 1; f < 3; f++) begin
        n_total++;
        if (got_cyc[f] - got_cyc[f-1] !== gap) $display("FAIL b2b_gap f%0d got %0d want %0d", f, got_cyc[f] - got_cyc[f-1], gap);
        else n_pass++;
      end
    end
    n_total++; if (idx !== 24) $display("FAIL b2b_accepted got %0d want 24", idx); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    test_reset();
    test_basic_sum();
    test_clamp();
    test_rail_recovery();
    test_overflow();
    test_backpressure();
    test_reset_mid_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
